// File: rtl/sdram_port_arb.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : sdram_port_arb                                                   |
// | Brief    : Round-robin arbiter of NUM_CH client channels onto one           |
// |            toggle-handshake SDRAM port. Define SDRAM_ARB_PRIO_EN to give    |
// |            channel 0 absolute priority.                                     |
// | Revision : 1.0                                                              |
// +----------------------------------------------------------------------------+
module sdram_port_arb #(
    parameter int NUM_CH     = 3,
    parameter int AW         = 25,
    parameter int RESYNC_CYC = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_CH-1:0]    ch_req,
    input  logic [NUM_CH-1:0]    ch_we,
    input  logic [NUM_CH*AW-1:0] ch_a,
    input  logic [NUM_CH*16-1:0] ch_d,
    input  logic [NUM_CH*2-1:0]  ch_ds,
    output logic [NUM_CH-1:0]    ch_ack,
    output logic [15:0]          ch_q,
    output logic                 sd_req,
    input  logic                 sd_ack,
    output logic                 sd_we,
    output logic [AW-1:0]        sd_a,
    output logic [15:0]          sd_d,
    output logic [1:0]           sd_ds,
    input  logic [15:0]          sd_q
);

    localparam int IW = (NUM_CH > 2) ? $clog2(NUM_CH) : 1;
    localparam int CW = $clog2(RESYNC_CYC + 1);

    typedef enum logic [2:0] {
        RESYNC = 3'd0,
        IDLE   = 3'd1,
        ISSUE  = 3'd2,
        WAIT   = 3'd3,
        ACK    = 3'd4
    } state_t;

    state_t          r_state;
    logic [IW-1:0]   r_grant;
    logic [IW-1:0]   r_last_grant;
    logic [CW-1:0]   r_resync_cnt;
    logic [IW-1:0]   w_sel;
    logic [IW-1:0]   w_cand;
    logic            w_any;

    // Search upward from the channel after the last grant, wrapping around.
    always_comb begin
        w_any  = 1'b0;
        w_sel  = '0;
        w_cand = '0;
        for (int k = 1; k <= NUM_CH; k++) begin
            w_cand = IW'((int'(r_last_grant) + k) % NUM_CH);
            if (!w_any && ch_req[w_cand]) begin
                w_any = 1'b1;
                w_sel = w_cand;
            end
        end
`ifdef SDRAM_ARB_PRIO_EN
        if (ch_req[0]) begin
            w_sel = '0;
        end
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= RESYNC;
            r_grant      <= '0;
            r_last_grant <= IW'(NUM_CH - 1);
            r_resync_cnt <= '0;
            sd_req       <= 1'b0;
            sd_we        <= 1'b0;
            sd_a         <= '0;
            sd_d         <= '0;
            sd_ds        <= 2'b00;
            ch_ack       <= '0;
            ch_q         <= '0;
        end else begin
            case (r_state)
                RESYNC: begin
                    // Track the SDRAM side so an interrupted transfer is absorbed.
                    sd_req <= sd_ack;
                    if (r_resync_cnt == CW'(RESYNC_CYC - 1)) begin
                        r_resync_cnt <= '0;
                        r_state      <= IDLE;
                    end else begin
                        r_resync_cnt <= r_resync_cnt + 1'b1;
                    end
                end
                IDLE: begin
                    if (w_any) begin
                        r_grant <= w_sel;
                        sd_we   <= ch_we[w_sel];
                        sd_a    <= ch_a[int'(w_sel)*AW +: AW];
                        sd_d    <= ch_d[int'(w_sel)*16 +: 16];
                        sd_ds   <= ch_ds[int'(w_sel)*2 +: 2];
                        r_state <= ISSUE;
                    end
                end
                ISSUE: begin
                    sd_req  <= ~sd_req;
                    r_state <= WAIT;
                end
                WAIT: begin
                    if (sd_ack == sd_req) begin
                        ch_q    <= sd_q;
                        ch_ack  <= NUM_CH'(1) << r_grant;
                        r_state <= ACK;
                    end
                end
                ACK: begin
`ifdef SDRAM_ARB_PRIO_EN
                    if (r_grant != '0) begin
                        r_last_grant <= r_grant;
                    end
`else
                    r_last_grant <= r_grant;
`endif
                    ch_ack  <= '0;
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= RESYNC;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
